// File: rtl/pipe_sched.sv
// rtl/pipe_sched.sv - MIPS pipeline stall/flush/redirect sequencer
// Optional MULT HI/LO interlock enabled by defining PIPE_SCHED_MULT_INTERLOCK_EN.
module pipe_sched #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0040,
    parameter int          MULT_CYCLES = 4,
    parameter int          FLUSH_HOLD  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic [7:0]  id_aluop_i,
    input  logic        mult_start_i,
    input  logic        mem_exc_valid_i,
    input  logic [31:0] mem_exc_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        mult_busy_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MASK = 1'b1;

    localparam logic [2:0] HOLD_LOAD = 3'(FLUSH_HOLD);

    localparam logic [5:0] STALL_EX = 6'b001111;
    localparam logic [5:0] STALL_ID = 6'b000111;

    logic [0:0] state;
    logic [2:0] hold_cnt;
    logic       exc_eret;
    logic       exc_syscall;
    logic       exc_ri;
    logic       exc_hit;
    logic       mult_busy;
    logic       hilo_hz;
    logic       unused_exc_bits;

    assign exc_eret    = mem_exc_i[12];
    assign exc_syscall = mem_exc_i[8];
    assign exc_ri      = ~mem_exc_i[9];

    assign unused_exc_bits = ^{mem_exc_i[31:13], mem_exc_i[11:10], mem_exc_i[7:0]};

    // Exceptions reaching MEM during MASK come from wrong-path slots being flushed.
    assign exc_hit = ~rst & mem_exc_valid_i & (exc_syscall | exc_eret | exc_ri)
                   & (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold_cnt <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (exc_hit) begin
                        state    <= ST_MASK;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                ST_MASK: begin
                    if (hold_cnt <= 3'd1) begin
                        state    <= ST_IDLE;
                        hold_cnt <= 3'd0;
                    end else begin
                        hold_cnt <= hold_cnt - 3'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= 3'd0;
                end
            endcase
        end
    end

`ifdef PIPE_SCHED_MULT_INTERLOCK_EN
    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);

    localparam logic [7:0] OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO = 8'b0001_0011;
    localparam logic [7:0] OP_MULT = 8'b0001_1000;

    logic [4:0] mcnt;

    // A flushed MULT (same cycle or already running) must not keep the interlock alive.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcnt <= 5'd0;
        end else if (exc_hit) begin
            mcnt <= 5'd0;
        end else if (mult_start_i) begin
            mcnt <= MULT_LOAD;
        end else if (mcnt != 5'd0) begin
            mcnt <= mcnt - 5'd1;
        end
    end

    assign mult_busy = (mcnt != 5'd0);

    always_comb begin
        hilo_hz = 1'b0;
        if (mult_busy) begin
            hilo_hz = (id_aluop_i == OP_MFHI) || (id_aluop_i == OP_MFLO) ||
                      (id_aluop_i == OP_MTHI) || (id_aluop_i == OP_MTLO) ||
                      (id_aluop_i == OP_MULT);
        end
    end
`else
    logic unused_mult;

    assign unused_mult = ^{mult_start_i, id_aluop_i};
    assign mult_busy   = 1'b0;
    assign hilo_hz     = 1'b0;
`endif

    assign mult_busy_o = mult_busy & ~rst;

    always_comb begin
        stall_o  = 6'b000000;
        flush_o  = 1'b0;
        new_pc_o = 32'h0000_0000;
        if (!rst) begin
            if (exc_hit) begin
                flush_o  = 1'b1;
                new_pc_o = exc_eret ? cp0_epc_i : EXC_VECTOR;
            end else if (stallreq_ex) begin
                stall_o = STALL_EX;
            end else if (stallreq_id || hilo_hz) begin
                stall_o = STALL_ID;
            end
        end
    end

endmodule

// File: tb/tb_pipe_sched.sv
// tb/tb_pipe_sched.sv - directed table plus randomized model check for pipe_sched
module tb_pipe_sched;

    localparam int          MC  = 4;
    localparam int          FH  = 2;
    localparam logic [31:0] VEC = 32'h0000_0040;
`ifdef PIPE_SCHED_MULT_INTERLOCK_EN
    localparam bit MI = 1'b1;
`else
    localparam bit MI = 1'b0;
`endif

    localparam logic [7:0] OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO = 8'b0001_0011;
    localparam logic [7:0] OP_MULT = 8'b0001_1000;
    localparam logic [7:0] OP_ADD  = 8'b0010_0000;

    localparam logic [5:0] S_ID  = 6'b000111;
    localparam logic [5:0] S_EX  = 6'b001111;
    localparam logic [5:0] S_MI  = MI ? 6'b000111 : 6'b000000;
    localparam logic       B_MI  = MI;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex;
    logic [7:0]  id_aluop_i;
    logic        mult_start_i, mem_exc_valid_i;
    logic [31:0] mem_exc_i, cp0_epc_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        mult_busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_sched #(.EXC_VECTOR(VEC), .MULT_CYCLES(MC), .FLUSH_HOLD(FH)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .id_aluop_i(id_aluop_i), .mult_start_i(mult_start_i),
        .mem_exc_valid_i(mem_exc_valid_i), .mem_exc_i(mem_exc_i), .cp0_epc_i(cp0_epc_i),
        .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o), .mult_busy_o(mult_busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, sid, sex;
        logic [7:0]  aluop;
        logic        mstart, valid;
        logic [31:0] exc, epc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, sid, sex, input logic [7:0] al, input logic ms, vl,
                       input logic [31:0] ex, ep, input logic [5:0] es, input logic ef,
                       input logic [31:0] epx, input logic eb);
        vec_t v;
        v.rst = r; v.sid = sid; v.sex = sex; v.aluop = al; v.mstart = ms; v.valid = vl;
        v.exc = ex; v.epc = ep; v.e_stall = es; v.e_flush = ef; v.e_pc = epx; v.e_busy = eb;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, sid, sex, input logic [7:0] al, input logic ms, vl,
                         input logic [31:0] ex, ep);
        rst = r; stallreq_id = sid; stallreq_ex = sex; id_aluop_i = al;
        mult_start_i = ms; mem_exc_valid_i = vl; mem_exc_i = ex; cp0_epc_i = ep;
    endtask

    task automatic check(input string name, input logic [5:0] es, input logic ef,
                         input logic [31:0] epx, input logic chk_pc, input logic eb);
        n_tests++;
        if (stall_o !== es || flush_o !== ef || mult_busy_o !== eb ||
            (chk_pc && new_pc_o !== epx)) begin
            n_fail++;
            $display("FAIL %s: got stall=%b flush=%b pc=%h busy=%b, want stall=%b flush=%b pc=%h busy=%b",
                     name, stall_o, flush_o, new_pc_o, mult_busy_o, es, ef, epx, eb);
        end
    endtask

    function automatic logic is_hilo(input logic [7:0] op);
        return op == OP_MFHI || op == OP_MFLO || op == OP_MTHI || op == OP_MTLO || op == OP_MULT;
    endfunction

    initial begin
        logic [31:0] W_SYS, W_ERET, W_NONE, EPC;
        int cyc, mask_end, busy_end;
        W_SYS = 32'h0000_0300; W_ERET = 32'h0000_1200; W_NONE = 32'h0000_0200;
        EPC = 32'hBFC0_0100;

        drive(1, 0, 0, OP_ADD, 0, 0, W_NONE, 0);

        //   rst sid sex aluop   ms vl exc     epc  e_stall e_flush e_pc  e_busy
        add(1, 1, 0, OP_ADD,  1, 1, W_SYS,  0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 1, 0, OP_ADD,  0, 0, W_NONE, 0,   S_ID,  0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 1, 1, OP_ADD,  0, 0, W_NONE, 0,   S_EX,  0, 32'h0, 0);
        add(0, 1, 0, OP_ADD,  0, 1, W_SYS,  EPC, 6'h00, 1, VEC,   0);
        add(0, 1, 0, OP_ADD,  0, 1, W_SYS,  EPC, S_ID,  0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 1, W_SYS,  EPC, 6'h00, 0, 32'h0, 0);
        add(0, 0, 1, OP_ADD,  0, 1, W_SYS,  EPC, 6'h00, 1, VEC,   0);
        add(0, 0, 0, OP_ADD,  0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 1, W_ERET, EPC, 6'h00, 1, EPC,   0);
        add(0, 0, 0, OP_ADD,  0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 1, 32'h0,  EPC, 6'h00, 1, VEC,   0);
        add(0, 0, 0, OP_ADD,  0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 0, 32'h0,  0,   6'h00, 0, 32'h0, 0);
        // MULT then MFLO held in ID
        add(0, 0, 0, OP_MFLO, 1, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_MFLO, 0, 0, W_NONE, 0,   S_MI,  0, 32'h0, B_MI);
        add(0, 0, 0, OP_MFLO, 0, 0, W_NONE, 0,   S_MI,  0, 32'h0, B_MI);
        add(0, 0, 0, OP_MFLO, 0, 0, W_NONE, 0,   S_MI,  0, 32'h0, B_MI);
        add(0, 0, 0, OP_MFLO, 0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        // MULT start flushed by exception in the same cycle
        add(0, 0, 0, OP_MULT, 1, 1, W_SYS,  0,   6'h00, 1, VEC,   0);
        add(0, 0, 0, OP_MFLO, 0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        // reset in the middle of a MULT
        add(0, 0, 0, OP_ADD,  1, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(1, 1, 1, OP_MFLO, 0, 1, W_SYS,  0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_MFLO, 0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        // exception while the multiplier is busy
        add(0, 0, 0, OP_ADD,  1, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_MFLO, 0, 1, W_SYS,  0,   6'h00, 1, VEC,   B_MI);
        add(0, 0, 0, OP_MFLO, 0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        // reset during MASK clears the exception mask
        add(0, 0, 0, OP_ADD,  0, 1, W_ERET, EPC, 6'h00, 1, EPC,   0);
        add(1, 0, 0, OP_ADD,  0, 1, W_SYS,  0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 1, W_SYS,  0,   6'h00, 1, VEC,   0);
        add(0, 0, 0, OP_ADD,  0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);
        add(0, 0, 0, OP_ADD,  0, 0, W_NONE, 0,   6'h00, 0, 32'h0, 0);

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i].rst, tbl[i].sid, tbl[i].sex, tbl[i].aluop, tbl[i].mstart,
                  tbl[i].valid, tbl[i].exc, tbl[i].epc);
            #4;
            check($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_flush, tbl[i].e_pc,
                  tbl[i].e_flush | tbl[i].rst, tbl[i].e_busy);
        end

        // Randomized run: the model tracks absolute cycle windows of masking and busy.
        cyc = 0; mask_end = -1; busy_end = -1;
        for (int i = 0; i < 3000; i++) begin
            logic r, sid, sex, ms, vl, eret, hit, busy, hz;
            logic [7:0]  al;
            logic [31:0] ex, ep, epx;
            logic [5:0]  es;
            int sel;
            r   = (i == 0) || ($urandom_range(0, 99) == 0);
            sid = ($urandom_range(0, 5) == 0);
            sex = ($urandom_range(0, 9) == 0);
            ms  = ($urandom_range(0, 7) == 0);
            vl  = ($urandom_range(0, 5) == 0);
            sel = $urandom_range(0, 4);
            case (sel)
                0: ex = 32'h0000_0300;
                1: ex = 32'h0000_1200;
                2: ex = 32'h0000_0200;
                3: ex = 32'h0000_0000;
                default: ex = $urandom;
            endcase
            ep = $urandom;
            sel = $urandom_range(0, 6);
            case (sel)
                0: al = OP_MFHI;
                1: al = OP_MFLO;
                2: al = OP_MTHI;
                3: al = OP_MTLO;
                4: al = OP_MULT;
                default: al = 8'($urandom);
            endcase
            @(posedge clk); #1;
            drive(r, sid, sex, al, ms, vl, ex, ep);
            #4;
            eret = ex[12];
            hit  = !r && vl && (ex[8] || ex[12] || !ex[9]) && (cyc > mask_end);
            busy = !r && MI && (cyc <= busy_end);
            hz   = busy && is_hilo(al);
            es   = 6'h00;
            epx  = 32'h0;
            if (r)        es = 6'h00;
            else if (hit) epx = eret ? ep : VEC;
            else if (sex) es = S_EX;
            else if (sid || hz) es = S_ID;
            check($sformatf("rnd%0d", i), es, hit, epx, hit | r, busy);
            if (r) begin
                mask_end = -1; busy_end = -1;
            end else if (hit) begin
                mask_end = cyc + FH; busy_end = -1;
            end else if (MI && ms) begin
                busy_end = cyc + MC - 1;
            end
            cyc++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
